// File: rtl/vga_scaled_fb_timing.sv
// VGA raster engine with a downscaled framebuffer read port.
//
// Generates programmable H/V timing and fetches framebuffer pixels. Each framebuffer pixel covers a
// 2^SCALE_SHIFT x 2^SCALE_SHIFT block of screen pixels. Returned pixel data is realigned with the
// sync and enable signals. Built-in test patterns are selected once per frame.
//
// Ports:
//   i_clk        pixel clock
//   i_rst        synchronous reset, active-high
//   i_mode       0 framebuffer, 1 colour bars, 2 checkerboard, 3 solid black
//   i_pix_data   framebuffer pixel {R,G,B}, valid RD_LATENCY cycles after o_fb_rd
//   o_fb_rd      framebuffer read strobe
//   o_fb_addr    framebuffer read address (row-major, downscaled); holds when o_fb_rd is low
//   o_red/o_green/o_blue  channel data, zero outside the active area
//   o_hsync/o_vsync       sync outputs, *_SYNC_POL is the level during the pulse
//   o_de         data enable (active video)
//   o_sof        pulse with the first active pixel of a frame
//   o_sol        pulse with the first active pixel of each active line
//
// Every output reaches the pins RD_LATENCY+2 cycles after its counter position.
module vga_scaled_fb_timing #(
  parameter int unsigned H_VISIBLE   = 800,
  parameter int unsigned H_FRONT     = 40,
  parameter int unsigned H_SYNC      = 128,
  parameter int unsigned H_BACK      = 88,
  parameter int unsigned V_VISIBLE   = 600,
  parameter int unsigned V_FRONT     = 1,
  parameter int unsigned V_SYNC      = 4,
  parameter int unsigned V_BACK      = 23,
  parameter bit          H_SYNC_POL  = 1'b1,
  parameter bit          V_SYNC_POL  = 1'b1,
  parameter int unsigned COLOR_BITS  = 2,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [1:0]              i_mode,
  input  logic [3*COLOR_BITS-1:0] i_pix_data,
  output logic                    o_fb_rd,
  output logic [ADDR_W-1:0]       o_fb_addr,
  output logic [COLOR_BITS-1:0]   o_red,
  output logic [COLOR_BITS-1:0]   o_green,
  output logic [COLOR_BITS-1:0]   o_blue,
  output logic                    o_hsync,
  output logic                    o_vsync,
  output logic                    o_de,
  output logic                    o_sof,
  output logic                    o_sol
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  // One spare count of headroom so the sync end bound always fits.
  localparam int unsigned HCW     = $clog2(H_TOTAL + 1);
  localparam int unsigned VCW     = $clog2(V_TOTAL + 1);
  localparam int unsigned PIX_W   = 3 * COLOR_BITS;

  localparam logic [HCW-1:0] H_LAST     = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_VIS_END  = HCW'(H_VISIBLE);
  localparam logic [HCW-1:0] H_SYNC_BEG = HCW'(H_VISIBLE + H_FRONT);
  localparam logic [HCW-1:0] H_SYNC_END = HCW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VCW-1:0] V_LAST     = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_VIS_END  = VCW'(V_VISIBLE);
  localparam logic [VCW-1:0] V_SYNC_BEG = VCW'(V_VISIBLE + V_FRONT);
  localparam logic [VCW-1:0] V_SYNC_END = VCW'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic [HCW-1:0]    H_BLK_MASK = HCW'((1 << SCALE_SHIFT) - 1);
  localparam logic [VCW-1:0]    V_BLK_MASK = VCW'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(H_VISIBLE >> SCALE_SHIFT);

  localparam int unsigned       BAR_W    = (H_VISIBLE / 8 > 0) ? H_VISIBLE / 8 : 1;
  localparam int unsigned       BAR_CW   = $clog2(BAR_W + 1);
  localparam logic [BAR_CW-1:0] BAR_LAST = BAR_CW'(BAR_W - 1);

  localparam logic [COLOR_BITS-1:0] CMAX = '1;

  // Per-pixel control carried alongside the framebuffer read.
  typedef struct packed {
    logic             de;
    logic             hs;
    logic             vs;
    logic             sof;
    logic             sol;
    logic             use_fb;
    logic [PIX_W-1:0] pat;
  } ctl_t;

  // ---------------------------------------------------------------------------------------------
  // Stage 0: raster counters, mode latch, address generator, pattern generator
  // ---------------------------------------------------------------------------------------------
  logic [HCW-1:0]    h_q, h_d;
  logic [VCW-1:0]    v_q, v_d;
  logic [1:0]        mode_q, mode_cur;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [BAR_CW-1:0] bar_px_q, bar_px_d;
  logic [2:0]        bar_idx_q, bar_idx_d;

  logic line_end, frame_start, h_vis, v_vis, vis;
  ctl_t ctl_s0;

  assign line_end    = (h_q == H_LAST);
  assign frame_start = (h_q == '0) && (v_q == '0);
  assign h_vis       = (h_q < H_VIS_END);
  assign v_vis       = (v_q < V_VIS_END);
  assign vis         = h_vis && v_vis;

  // The mode is only picked up at the frame origin so a frame never mixes sources.
  assign mode_cur = frame_start ? i_mode : mode_q;

  always_comb begin
    h_d = h_q + HCW'(1);
    v_d = v_q;
    if (line_end) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + VCW'(1);
    end
  end

  // Incremental address: step once per block, rewind to the row base at line end and move the
  // base down a row after the last screen line of each block row.
  always_comb begin
    addr_d = addr_q;
    base_d = base_q;
    if (line_end) begin
      if (v_q == V_LAST) begin
        base_d = '0;
      end else if ((v_q & V_BLK_MASK) == V_BLK_MASK) begin
        base_d = base_q + ROW_STRIDE;
      end
      addr_d = base_d;
    end else if (h_vis && ((h_q & H_BLK_MASK) == H_BLK_MASK)) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  // Bar index tracked with a small counter instead of dividing h_cnt; saturates on bar 7 so any
  // remainder pixels of a non-multiple-of-8 width stay white.
  always_comb begin
    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;
    if (line_end) begin
      bar_px_d  = '0;
      bar_idx_d = '0;
    end else if (h_vis) begin
      if (bar_px_q == BAR_LAST) begin
        bar_px_d = '0;
        if (bar_idx_q != 3'd7) begin
          bar_idx_d = bar_idx_q + 3'd1;
        end
      end else begin
        bar_px_d = bar_px_q + BAR_CW'(1);
      end
    end
  end

  always_comb begin
    ctl_s0        = '0;
    ctl_s0.de     = vis;
    ctl_s0.hs     = (h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END);
    ctl_s0.vs     = (v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END);
    ctl_s0.sof    = frame_start;
    ctl_s0.sol    = (h_q == '0) && v_vis;
    ctl_s0.use_fb = (mode_cur == 2'd0);
    unique case (mode_cur)
      2'd1: ctl_s0.pat = {bar_idx_q[2] ? CMAX : '0,
                          bar_idx_q[1] ? CMAX : '0,
                          bar_idx_q[0] ? CMAX : '0};
      2'd2: ctl_s0.pat = (h_q[SCALE_SHIFT] ^ v_q[SCALE_SHIFT]) ? '1 : '0;
      default: ctl_s0.pat = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_q       <= '0;
      v_q       <= '0;
      mode_q    <= i_mode;
      addr_q    <= '0;
      base_q    <= '0;
      bar_px_q  <= '0;
      bar_idx_q <= '0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      mode_q    <= mode_cur;
      addr_q    <= addr_d;
      base_q    <= base_d;
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stage 1: framebuffer request, control delay line matched to the read latency
  // ---------------------------------------------------------------------------------------------
  logic              fb_rd_q;
  logic [ADDR_W-1:0] fb_addr_q;
  logic              fb_req;
  ctl_t              ctl_q [RD_LATENCY+1];

  assign fb_req = vis && ctl_s0.use_fb;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fb_rd_q   <= 1'b0;
      fb_addr_q <= '0;
      for (int i = 0; i <= int'(RD_LATENCY); i++) begin
        ctl_q[i] <= '0;
      end
    end else begin
      fb_rd_q <= fb_req;
      if (fb_req) begin
        fb_addr_q <= addr_q;
      end
      ctl_q[0] <= ctl_s0;
      for (int i = 1; i <= int'(RD_LATENCY); i++) begin
        ctl_q[i] <= ctl_q[i-1];
      end
    end
  end

  assign o_fb_rd   = fb_rd_q;
  assign o_fb_addr = fb_addr_q;

  // ---------------------------------------------------------------------------------------------
  // Output register: ctl_q[RD_LATENCY] lines up with i_pix_data for the same pixel
  // ---------------------------------------------------------------------------------------------
  ctl_t             ctl_o;
  logic [PIX_W-1:0] col_d, col_q;
  logic             de_q, hs_q, vs_q, sof_q, sol_q;

  assign ctl_o = ctl_q[RD_LATENCY];

  always_comb begin
    col_d = '0;
    if (ctl_o.de) begin
      col_d = ctl_o.use_fb ? i_pix_data : ctl_o.pat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col_q <= '0;
      de_q  <= 1'b0;
      hs_q  <= ~H_SYNC_POL;
      vs_q  <= ~V_SYNC_POL;
      sof_q <= 1'b0;
      sol_q <= 1'b0;
    end else begin
      col_q <= col_d;
      de_q  <= ctl_o.de;
      hs_q  <= ctl_o.hs ? H_SYNC_POL : ~H_SYNC_POL;
      vs_q  <= ctl_o.vs ? V_SYNC_POL : ~V_SYNC_POL;
      sof_q <= ctl_o.sof;
      sol_q <= ctl_o.sol;
    end
  end

  assign {o_red, o_green, o_blue} = col_q;
  assign o_de    = de_q;
  assign o_hsync = hs_q;
  assign o_vsync = vs_q;
  assign o_sof   = sof_q;
  assign o_sol   = sol_q;

endmodule
